// File: rtl/lenet5_host_if.sv
// Host front end for lenet5: assembles one pixel map, runs the accelerator with timeout, returns the class.
// Latency: o_ce rises the cycle after the last pixel; pixels stall in RUN/HOLD, result waits for i_res_ready.
module lenet5_host_if #(
  parameter int I_BW        = 8,
  parameter int IF_SIZE     = 28,
  parameter int TIMEOUT_CYC = 65536,
  localparam int NPIX       = IF_SIZE * IF_SIZE,
  localparam int PW         = $clog2(NPIX),
  localparam int CW         = $clog2(TIMEOUT_CYC)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_pix_valid,
  input  logic [I_BW-1:0]      i_pix_data,
  output logic                 o_pix_ready,
  output logic [NPIX*I_BW-1:0] o_fmap,
  output logic                 o_ce,
  input  logic                 i_end,
  input  logic [3:0]           i_result,
  output logic                 o_res_valid,
  output logic [3:0]           o_res_data,
  output logic                 o_res_err,
  input  logic                 i_res_ready,
  output logic                 o_busy
);

  typedef enum logic [1:0] {LOAD, RUN, HOLD} state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       pix_cnt_q, pix_cnt_d;
  logic [CW-1:0]       cyc_cnt_q, cyc_cnt_d;
  logic [NPIX*I_BW-1:0] fmap_q;
  logic                ce_q, res_valid_q, res_err_q, res_err_d;
  logic [3:0]          res_data_q, res_data_d;
  logic                wr_en;

  always_comb begin
    state_d    = state_q;
    pix_cnt_d  = pix_cnt_q;
    cyc_cnt_d  = cyc_cnt_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    wr_en      = 1'b0;
    case (state_q)
      LOAD: begin
        if (i_pix_valid) begin
          wr_en = 1'b1;
          if (pix_cnt_q == PW'(NPIX - 1)) begin
            state_d   = RUN;
            pix_cnt_d = '0;
            cyc_cnt_d = '0;
          end else begin
            pix_cnt_d = pix_cnt_q + PW'(1);
          end
        end
      end
      RUN: begin
        // i_end has priority over a coincident timeout
        if (i_end) begin
          state_d    = HOLD;
          res_data_d = i_result;
          res_err_d  = 1'b0;
        end else if (cyc_cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          state_d    = HOLD;
          res_data_d = 4'hF;
          res_err_d  = 1'b1;
        end else begin
          cyc_cnt_d = cyc_cnt_q + CW'(1);
        end
      end
      HOLD: begin
        if (i_res_ready) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      pix_cnt_q   <= '0;
      cyc_cnt_q   <= '0;
      fmap_q      <= '0;
      ce_q        <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= 4'h0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      cyc_cnt_q   <= cyc_cnt_d;
      ce_q        <= (state_d == RUN);
      res_valid_q <= (state_d == HOLD);
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      if (wr_en) fmap_q[int'(pix_cnt_q)*I_BW +: I_BW] <= i_pix_data;
    end
  end

  assign o_pix_ready = (state_q == LOAD);
  assign o_busy      = (state_q != LOAD);
  assign o_fmap      = fmap_q;
  assign o_ce        = ce_q;
  assign o_res_valid = res_valid_q;
  assign o_res_data  = res_data_q;
  assign o_res_err   = res_err_q;

endmodule

// File: doc/lenet5_host_if.md
# lenet5_host_if

Host-side front end for the lenet5 accelerator. It accepts a serial pixel stream with a valid/ready handshake and assembles one full IF_SIZE x IF_SIZE feature map on the flattened `o_fmap` bus. It then holds the accelerator's `ce` high until the accelerator reports done, and returns the 4-bit class result through a valid/ready handshake. It sits between the image source (UART/DMA bridge) and the lenet5 top.

## Interface
Parameters:
- `I_BW`, 8, pixel bit width; equals the accelerator's input pixel width.
- `IF_SIZE`, 28, feature-map side length; NPIX = IF_SIZE*IF_SIZE.
- `TIMEOUT_CYC`, 65536, maximum RUN cycles before the inference is aborted; must be ≥ 2.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `i_pix_valid`  in  1  a pixel is offered.
- `i_pix_data`  in  I_BW  pixel value, raster order.
- `o_pix_ready`  out  1  block accepts a pixel.
- `o_fmap`  out  NPIX*I_BW  assembled map; pixel k occupies bits [k*I_BW +: I_BW].
- `o_ce`  out  1  accelerator clock enable.
- `i_end`  in  1  accelerator done (its `o_end`).
- `i_result`  in  4  accelerator class result (its `o_result`).
- `o_res_valid`  out  1  result available.
- `o_res_data`  out  4  captured class 0-9, or 4'hF on timeout.
- `o_res_err`  out  1  qualifies `o_res_data`; 1 = timeout abort.
- `i_res_ready`  in  1  consumer takes the result.
- `o_busy`  out  1  high in RUN or HOLD.

## Operation
- The FSM has three states: LOAD, RUN and HOLD. Reset enters LOAD.
- Reset values:
  - pixel counter = 0, cycle counter = 0.
  - `o_fmap` = 0, `o_ce` = 0.
  - `o_res_valid` = 0, `o_res_data` = 0, `o_res_err` = 0.
  - `o_busy` = 0, `o_pix_ready` = 1.
- LOAD:
  - `o_pix_ready` = 1.
  - On each `i_pix_valid & o_pix_ready`, write `i_pix_data` to slot `pix_cnt` and increment `pix_cnt`.
  - An accepted pixel with `pix_cnt == NPIX-1` → RUN; `pix_cnt` clears to 0 and the cycle counter clears to 0.
  - `i_end` is ignored in LOAD.
- RUN:
  - `o_ce` = 1, `o_pix_ready` = 0. `o_fmap` is frozen.
  - The cycle counter increments every cycle.
  - `i_end` = 1 → HOLD; capture `i_result` into `o_res_data` and set `o_res_err` = 0.
  - Otherwise, cycle counter == TIMEOUT_CYC-1 → HOLD with `o_res_data` = 4'hF and `o_res_err` = 1.
  - If `i_end` and the timeout coincide, `i_end` wins.
- HOLD:
  - `o_res_valid` = 1, `o_ce` = 0, `o_pix_ready` = 0. `o_res_data` and `o_res_err` are stable.
  - `i_res_ready` = 1 → LOAD.
  - `i_end` is ignored in HOLD.
- `o_fmap` keeps the last image until it is overwritten slot by slot in the next LOAD; slots are never bulk-cleared except by `rst`.
- `rst` asserted in any state, including mid-load or mid-run, returns everything to reset values on the next edge. A partial image is discarded.
- Counter widths are $clog2(NPIX) and $clog2(TIMEOUT_CYC); neither counter wraps.

## Timing
- All outputs are registered, except `o_pix_ready` and `o_busy`, which are decoded from the state register.
- Last pixel accepted at edge t → `o_ce` = 1 from cycle t+1.
- `i_end` sampled high at edge t → at t+1 `o_ce` = 0, `o_res_valid` = 1 and `o_res_data` = the value of `i_result` at t.
- Timeout: `o_ce` is high for exactly TIMEOUT_CYC cycles, then `o_res_valid` rises on the next cycle.
- Result handshake at edge t → `o_res_valid` = 0 and `o_pix_ready` = 1 at t+1. The first pixel of the next image can be accepted at edge t+1.
- Throughput in LOAD is one pixel per cycle when `i_pix_valid` is held high; bubbles on `i_pix_valid` are allowed.
- `i_res_ready` may be held high permanently; the result is then visible for exactly one cycle.

## Test plan
- Reset then stream 784 pixels, value = k mod 256, with `i_pix_valid` held high → `o_fmap` byte k = k mod 256; `o_ce` rises the cycle after the 784th accept; `o_pix_ready` = 0 during RUN.
- In RUN, drive `i_end` = 1 with `i_result` = 7 at cycle 50 → next cycle `o_ce` = 0, `o_res_valid` = 1, `o_res_data` = 7, `o_res_err` = 0. Hold `i_res_ready` = 0 for 10 cycles → outputs stable. Then assert `i_res_ready` → next cycle state is LOAD.
- With TIMEOUT_CYC = 16 and no `i_end` → `o_ce` high for exactly 16 cycles, then `o_res_data` = 4'hF and `o_res_err` = 1. Repeat with `i_end` arriving on the 16th cycle → `o_res_data` = `i_result` and `o_res_err` = 0.
- Randomly toggle `i_pix_valid` during load, and drive `i_end` = 1 while in LOAD → no spurious transition; image is correct after 784 accepts.
- Assert `rst` after 300 pixels, and again mid-RUN → all outputs at reset values; the next full 784-pixel load runs normally.
- Back-to-back: two images with `i_res_ready` tied high and results 3 then 9 → two single-cycle `o_res_valid` pulses carrying 3 and 9; the second image's pixels are accepted starting the cycle after the first handshake.
